// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encoding
// and a small decode helper used by the datapath and the frame counter.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        SHR_HOLD  = 2'b00,
        SHR_RIGHT = 2'b01,
        SHR_LEFT  = 2'b10,
        SHR_LOAD  = 2'b11
    } shreg_mode_t;

    // True for either shift direction; the frame counter does not care which.
    function automatic logic is_shift(input shreg_mode_t m);
        return (m == SHR_RIGHT) || (m == SHR_LEFT);
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame counter for the universal shift register. Counts qualified shifts
// modulo WIDTH and emits a one-cycle done pulse in the cycle after the shift
// that completes a frame. A parallel load restarts the frame silently.
// The caller must pre-qualify shift/load with the clock enable.
module shift_frame_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Next count and done pulse; done is low on every cycle that does not wrap.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (shift) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter state with asynchronous reset abandoning any partial frame.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Serial and parallel outputs come straight from the register.
// Optional frame counter enabled by defining SHIFT_REG_UNIV_FRAME_CNT_EN;
// without it shift_cnt and frame_done are tied low and no counter exists.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     sin_r,
    input  logic                     sin_l,
    input  logic [WIDTH-1:0]         pin,
    output logic [WIDTH-1:0]         pout,
    output logic                     sout_r,
    output logic                     sout_l,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     frame_done
);

    localparam int CNT_W = $clog2(WIDTH);

    shreg_mode_t      mode_e;
    logic [WIDTH-1:0] q_q, q_d;

    assign mode_e = shreg_mode_t'(mode);

    // Next register value; disabled cycles and HOLD keep the current contents.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_e)
                SHR_RIGHT: q_d = {sin_r, q_q[WIDTH-1:1]};
                SHR_LEFT:  q_d = {q_q[WIDTH-2:0], sin_l};
                SHR_LOAD:  q_d = pin;
                default:   q_d = q_q;
            endcase
        end
    end

    // Data register; reset overrides the clock asynchronously.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign pout   = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

`ifdef SHIFT_REG_UNIV_FRAME_CNT_EN
    logic shift_en;
    logic load_en;

    assign shift_en = en & is_shift(mode_e);
    assign load_en  = en & (mode_e == SHR_LOAD);

    shift_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .Clk   (Clk),
        .rst   (rst),
        .shift (shift_en),
        .load  (load_en),
        .cnt   (shift_cnt),
        .done  (frame_done)
    );
`else
    assign shift_cnt  = {CNT_W{1'b0}};
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, RST_VAL=0). Counter expectations
// collapse to zero when SHIFT_REG_UNIV_FRAME_CNT_EN is not defined.
module tb_shift_reg_univ;

    localparam int W = 8;

`ifdef SHIFT_REG_UNIV_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         Clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] pin;
    logic [W-1:0] pout;
    logic         sout_r;
    logic         sout_l;
    logic [2:0]   shift_cnt;
    logic         frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] pin;
        logic [7:0] pout;
        logic [2:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    shift_reg_univ #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .Clk        (Clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ep, input logic [2:0] ec, input logic ed);
        check({tag, " pout"},       64'(pout),       64'(ep));
        check({tag, " sout_r"},     64'(sout_r),     64'(ep[0]));
        check({tag, " sout_l"},     64'(sout_l),     64'(ep[7]));
        check({tag, " shift_cnt"},  64'(shift_cnt),  CNT_EN ? 64'(ec) : 64'd0);
        check({tag, " frame_done"}, 64'(frame_done), CNT_EN ? 64'(ed) : 64'd0);
    endtask

    task automatic add(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] p, input logic [7:0] ep, input logic [2:0] ec, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pin = p;
        v.pout = ep; v.cnt = ec; v.done = ed;
        vecs.push_back(v);
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl, input logic [7:0] p);
        en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // SISO right: 1,0,1,1,0,0,0,0; first bit reaches sout_r on the 8th shift
        add(1, 2'b01, 1, 0, 8'h00, 8'h80, 3'd1, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h40, 3'd2, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hA0, 3'd3, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hD0, 3'd4, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h68, 3'd5, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h34, 3'd6, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h1A, 3'd7, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h0D, 3'd0, 1);
        add(1, 2'b00, 1, 1, 8'hFF, 8'h0D, 3'd0, 0);
        // Load C3, PISO left with sin_l=0: sout_l = 1,1,0,0,0,0,1,1 then 00
        add(1, 2'b11, 0, 0, 8'hC3, 8'hC3, 3'd0, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h86, 3'd1, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h0C, 3'd2, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h18, 3'd3, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h30, 3'd4, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h60, 3'd5, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hC0, 3'd6, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h80, 3'd7, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'h00, 3'd0, 1);
        // Enable gap: 3 shifts, 5 disabled cycles, 5 shifts
        add(1, 2'b01, 1, 0, 8'h00, 8'h80, 3'd1, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hC0, 3'd2, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hE0, 3'd3, 0);
        add(0, 2'b01, 0, 0, 8'h00, 8'hE0, 3'd3, 0);
        add(0, 2'b10, 1, 1, 8'h55, 8'hE0, 3'd3, 0);
        add(0, 2'b11, 0, 0, 8'h55, 8'hE0, 3'd3, 0);
        add(0, 2'b01, 0, 0, 8'h00, 8'hE0, 3'd3, 0);
        add(0, 2'b01, 0, 0, 8'h00, 8'hE0, 3'd3, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hF0, 3'd4, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hF8, 3'd5, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hFC, 3'd6, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hFE, 3'd7, 0);
        add(1, 2'b01, 1, 0, 8'h00, 8'hFF, 3'd0, 1);
        // Load mid-frame: 5 shifts, load 0F, then 8 shifts with a direction change
        add(1, 2'b10, 0, 0, 8'h00, 8'hFE, 3'd1, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hFC, 3'd2, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hF8, 3'd3, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hF0, 3'd4, 0);
        add(1, 2'b10, 0, 0, 8'h00, 8'hE0, 3'd5, 0);
        add(1, 2'b11, 0, 0, 8'h0F, 8'h0F, 3'd0, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'h1F, 3'd1, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'h3F, 3'd2, 0);
        add(1, 2'b10, 0, 1, 8'h00, 8'h7F, 3'd3, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h3F, 3'd4, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h1F, 3'd5, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h0F, 3'd6, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h07, 3'd7, 0);
        add(1, 2'b01, 0, 0, 8'h00, 8'h03, 3'd0, 1);
        add(1, 2'b00, 0, 0, 8'h00, 8'h03, 3'd0, 0);

        // Reset state before any clock edge
        rst = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pin = 8'h00;
        #1;
        check_all("por", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].pin);
            check_all($sformatf("vec%0d", i), vecs[i].pout, vecs[i].cnt, vecs[i].done);
        end

        // Asynchronous reset mid-frame after loading A5
        step(1, 2'b11, 0, 0, 8'hA5);
        step(1, 2'b01, 0, 0, 8'h00);
        step(1, 2'b01, 0, 0, 8'h00);
        check_all("pre_rst", 8'h29, 3'd2, 1'b0);
        en = 1'b1; mode = 2'b11; pin = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 3'd0, 1'b0);
        @(posedge Clk);
        #1;
        check_all("rst_edge", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        // First shift after release counts as shift 1; done only on the 8th
        for (int k = 1; k <= 8; k++) begin
            step(1, 2'b01, 1, 0, 8'h00);
            check_all($sformatf("post_rst%0d", k), 8'(16'hFF00 >> k), 3'(k % 8), k == 8);
        end
        step(1, 2'b01, 0, 0, 8'h00);
        check_all("no_double_done", 8'h7F, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
